// File: rtl/hazard_sb.sv
// Pipeline hazard controller: per-stage pause/bubble and PC hold from memory freeze,
// flush requests, load-use hazards and a multi-cycle register scoreboard.
module hazard_sb #(
    parameter int unsigned NSTAGE    = 4,
    parameter int unsigned NREG      = 32,
    parameter int unsigned REGW      = 5,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned SB_BYPASS = 0,
    parameter int unsigned PERFW     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] flush_req,
    input  logic              redirect,
    input  logic              mem_busy,
    input  logic              ex_load,
    input  logic [REGW-1:0]   ex_rd,
    input  logic [REGW-1:0]   id_rs1,
    input  logic [REGW-1:0]   id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REGW-1:0]   id_rd,
    input  logic              id_wr,
    input  logic              mc_issue,
    input  logic [REGW-1:0]   mc_rd,
    input  logic              mc_done,
    input  logic [REGW-1:0]   mc_done_rd,
    output logic              pc_pause,
    output logic [NSTAGE-1:0] pipe_pause,
    output logic [NSTAGE-1:0] pipe_bubble,
    output logic [NREG-1:0]   sb_busy,
    output logic [PERFW-1:0]  stall_cnt
);

    localparam int unsigned CNTW = 3;

    logic [CNTW-1:0]   ld_cnt_q, ld_cnt_d;
    logic [REGW-1:0]   ld_rd_q, ld_rd_d;
    logic [NREG-1:0]   sb_q, sb_d, sb_view;
    logic [PERFW-1:0]  stall_q, stall_d;
    logic [NSTAGE-1:0] flush_vec, flush_mask;
    logic              flush_any, load_hz, hold_hz, sb_hz, data_hz;

    function automatic logic src_hit(input logic [REGW-1:0] r,
                                     input logic [REGW-1:0] rs1,
                                     input logic [REGW-1:0] rs2,
                                     input logic            use1,
                                     input logic            use2);
        return (r != '0) && ((use1 && (rs1 == r)) || (use2 && (rs2 == r)));
    endfunction

    assign load_hz = ex_load && src_hit(ex_rd, id_rs1, id_rs2, id_rs1_used, id_rs2_used);
    assign hold_hz = (ld_cnt_q != '0) &&
                     src_hit(ld_rd_q, id_rs1, id_rs2, id_rs1_used, id_rs2_used);

    always_comb begin
        sb_view = sb_q;
        if (SB_BYPASS != 0 && mc_done) begin
            sb_view[mc_done_rd] = 1'b0;
        end
    end

    assign sb_hz = (id_rs1_used && (id_rs1 != '0) && sb_view[id_rs1]) ||
                   (id_rs2_used && (id_rs2 != '0) && sb_view[id_rs2]) ||
                   (id_wr && (id_rd != '0) && sb_view[id_rd]);
    assign data_hz = load_hz || hold_hz || sb_hz;

    // Bubble every stage from the oldest requester up to IF/ID.
    always_comb begin : p_flush
        logic acc;
        flush_vec = flush_req | (NSTAGE'(redirect) << (NSTAGE - 2));
        acc = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            acc           = acc | flush_vec[i];
            flush_mask[i] = acc;
        end
    end
    assign flush_any = |flush_vec;

    always_comb begin
        pc_pause    = 1'b0;
        pipe_pause  = '0;
        pipe_bubble = '0;
        if (mem_busy) begin
            pc_pause   = 1'b1;
            pipe_pause = '1;
        end else if (flush_any) begin
            pc_pause    = 1'b1;
            pipe_bubble = flush_mask;
        end else if (data_hz) begin
            pc_pause                = 1'b1;
            pipe_pause[NSTAGE-1]    = 1'b1;
            pipe_bubble[NSTAGE-2]   = 1'b1;
        end
    end

    // Load countdown freezes with the pipe; a flush kills the pending load.
    always_comb begin
        ld_cnt_d = ld_cnt_q;
        ld_rd_d  = ld_rd_q;
        if (!mem_busy) begin
            if (flush_any) begin
                ld_cnt_d = '0;
            end else if (load_hz && (LOAD_LAT > 1)) begin
                ld_cnt_d = CNTW'(LOAD_LAT - 1);
                ld_rd_d  = ex_rd;
            end else if (ld_cnt_q != '0) begin
                ld_cnt_d = ld_cnt_q - CNTW'(1);
            end
        end
    end

    // Set after clear so a same-register issue wins over a write-back.
    always_comb begin
        sb_d = sb_q;
        if (mc_done) begin
            sb_d[mc_done_rd] = 1'b0;
        end
        if (mc_issue && (mc_rd != '0) && !pc_pause) begin
            sb_d[mc_rd] = 1'b1;
        end
    end

    assign stall_d = (pc_pause && (stall_q != '1)) ? stall_q + PERFW'(1) : stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt_q <= '0;
            ld_rd_q  <= '0;
            sb_q     <= '0;
            stall_q  <= '0;
        end else begin
            ld_cnt_q <= ld_cnt_d;
            ld_rd_q  <= ld_rd_d;
            sb_q     <= sb_d;
            stall_q  <= stall_d;
        end
    end

    assign sb_busy   = sb_q;
    assign stall_cnt = stall_q;

endmodule
